// File: rtl/adc_serial_pkg.sv
// Shared definitions for the ADC0834-class serial link: FSM states, address
// layout and channel index encoding (used by both responder and reader).
package adc_serial_pkg;

    localparam int ADDR_BITS = 3;
    localparam int NUM_CH    = 4;
    localparam int CH_IDX_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        ADDR,
        SETTLE,
        DATA,
        DONE
    } state_t;

    // Address bits arrive in this order after the start bit.
    typedef struct packed {
        logic sgl;
        logic odd;
        logic sel;
    } addr_t;

    function automatic logic [CH_IDX_W-1:0] ch_index(input addr_t a);
        return {a.sel, a.odd};
    endfunction

endpackage

// File: rtl/adc_serial_responder_if.sv
// Pad-level serial bus between the ADC reader (master) and the ADC device (slave).
interface adc_serial_responder_if;
    logic cs_n;
    logic sclk;
    logic di;
    logic do_out;
    logic do_oe;
    logic sars;

    // No handshake: the master owns cs_n/sclk/di, the device answers on do_out
    // (qualified by do_oe) and reports conversion status on sars.
    modport master (output cs_n, sclk, di, input do_out, do_oe, sars);
    modport slave  (input cs_n, sclk, di, output do_out, do_oe, sars);
endinterface

// File: rtl/adc_serial_responder_line_sync_edge.sv
// N-stage synchronizer for an asynchronous line with single-cycle rise/fall
// pulses derived from the synchronized level.
module line_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{INIT}};
            prev_q <= INIT;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Device-side emulation of a 4-channel, 8-bit serial ADC: decodes the address
// after the start bit and shifts a snapshot of the chosen channel MSB-first.
module adc_serial_responder
    import adc_serial_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    adc_serial_responder_if.slave    bus,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     busy,
    output logic [CH_IDX_W-1:0]      last_ch,
    output logic [15:0]              conv_count,
    output state_t                   state_dbg
);

    localparam int BCNT_W = ($clog2(DATA_W) > 2) ? $clog2(DATA_W) : 2;

    logic sclk_q, sclk_rise, sclk_fall;
    logic cs_q, unused_cs_rise, unused_cs_fall;
    logic di_q, unused_di_rise, unused_di_fall;

    line_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(bus.sclk),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    line_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(bus.cs_n),
        .q(cs_q), .rise(unused_cs_rise), .fall(unused_cs_fall)
    );

    line_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_di (
        .clk(clk), .reset(reset), .d(bus.di),
        .q(di_q), .rise(unused_di_rise), .fall(unused_di_fall)
    );

    state_t              state;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [ADDR_BITS-1:0] addr_q;
    logic                settle_fell;
    logic [DATA_W-1:0]   result_q;
    logic                do_out_q, do_oe_q, sars_q;
    logic [CH_IDX_W-1:0] last_ch_q;
    logic [15:0]         conv_count_q;

    logic [DATA_W-1:0]   ch [NUM_CH];
    logic [CH_IDX_W-1:0] idx;
    logic [DATA_W-1:0]   ch_sel, ch_pair, snap_val;
    addr_t               addr_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch[i] = ch_data[i*DATA_W +: DATA_W];
    end

    // Differential mode subtracts the paired channel and clamps at zero.
    assign addr_s   = addr_t'(addr_q);
    assign idx      = ch_index(addr_s);
    assign ch_sel   = ch[idx];
    assign ch_pair  = ch[idx ^ CH_IDX_W'(1)];
    assign snap_val = addr_s.sgl ? ch_sel
                    : ((ch_sel > ch_pair) ? (ch_sel - ch_pair) : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            addr_q       <= '0;
            settle_fell  <= 1'b0;
            result_q     <= '0;
            do_out_q     <= 1'b0;
            do_oe_q      <= 1'b0;
            sars_q       <= 1'b0;
            last_ch_q    <= '0;
            conv_count_q <= '0;
        end else if (state != IDLE && cs_q) begin
            // Deselect overrides any sclk event and aborts an unfinished transfer.
            state    <= IDLE;
            do_out_q <= 1'b0;
            do_oe_q  <= 1'b0;
            sars_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs_q) begin
                        state       <= WAIT_START;
                        settle_fell <= 1'b0;
                    end
                end
                WAIT_START: begin
                    if (sclk_rise && di_q) begin
                        state   <= ADDR;
                        bit_cnt <= '0;
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        addr_q <= {addr_q[ADDR_BITS-2:0], di_q};
                        if (bit_cnt == BCNT_W'(ADDR_BITS-1)) begin
                            state       <= SETTLE;
                            settle_fell <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BCNT_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (sclk_fall && !settle_fell) begin
                        settle_fell <= 1'b1;
                        sars_q      <= 1'b1;
                        do_oe_q     <= 1'b1;
                        do_out_q    <= 1'b0;
                    end else if (sclk_rise && settle_fell) begin
                        result_q <= snap_val;
                        bit_cnt  <= BCNT_W'(DATA_W-1);
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        do_out_q <= result_q[bit_cnt];
                        if (bit_cnt == '0) begin
                            state        <= DONE;
                            last_ch_q    <= idx;
                            conv_count_q <= conv_count_q + 16'd1;
                        end else begin
                            bit_cnt <= bit_cnt - BCNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (sclk_fall) begin
                        sars_q   <= 1'b0;
                        do_out_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.do_out = do_out_q;
    assign bus.do_oe  = do_oe_q;
    assign bus.sars   = sars_q;
    assign busy       = (state != IDLE);
    assign last_ch    = last_ch_q;
    assign conv_count = conv_count_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: a table of transfers plus
// hand-written abort, reset and counter-wrap sequences.
module tb_adc_serial_responder;
    import adc_serial_pkg::*;

    localparam int H = 8;  // clk cycles per sclk phase

    logic        clk;
    logic        reset;
    logic [31:0] ch_data;
    logic        busy;
    logic [1:0]  last_ch;
    logic [15:0] conv_count;
    state_t      state_dbg;

    int n_checks;
    int n_fail;

    adc_serial_responder_if sif ();

    adc_serial_responder #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(sif),
        .ch_data(ch_data),
        .busy(busy),
        .last_ch(last_ch),
        .conv_count(conv_count),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          lead;
        logic [2:0]  addr;     // {sgl, odd, sel}
        logic [31:0] ch_pre;
        logic [31:0] ch_post;  // applied after the mux-settle rise
        logic [7:0]  exp_byte;
        logic [1:0]  exp_ch;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (H) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sif.di = b;
        half();
        sif.sclk = 1'b1;
        half();
        sif.sclk = 1'b0;
    endtask

    // Leaves sclk low just after the fall that follows SELECT.
    task automatic start_xfer(input int lead, input logic [2:0] addr);
        sif.sclk = 1'b0;
        sif.cs_n = 1'b0;
        half();
        for (int i = 0; i < lead; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(addr[2]);
        send_bit(addr[1]);
        sif.di = addr[0];
        half();
        sif.sclk = 1'b1;
        half();
        check("sars_before_settle_fall", sif.sars, 1'b0);
        sif.sclk = 1'b0;
        half();
        check("sars_after_settle_fall", sif.sars, 1'b1);
        check("do_oe_after_settle_fall", sif.do_oe, 1'b1);
        check("do_out_after_settle_fall", sif.do_out, 1'b0);
    endtask

    task automatic settle();
        sif.sclk = 1'b1;
        half();
    endtask

    task automatic data_bit(output logic b);
        sif.sclk = 1'b0;
        half();
        b = sif.do_out;
        sif.sclk = 1'b1;
        half();
    endtask

    task automatic finish_xfer();
        sif.sclk = 1'b0;
        half();
        check("sars_done", sif.sars, 1'b0);
        check("do_oe_done", sif.do_oe, 1'b1);
        check("do_out_done", sif.do_out, 1'b0);
        sif.cs_n = 1'b1;
        half();
        check("do_oe_idle", sif.do_oe, 1'b0);
        check("busy_idle", busy, 1'b0);
    endtask

    task automatic full_xfer(input int lead, input logic [2:0] addr,
                             input logic [31:0] ch_post, output logic [7:0] got);
        logic b;
        start_xfer(lead, addr);
        settle();
        ch_data = ch_post;
        got = '0;
        for (int i = 0; i < 8; i++) begin
            data_bit(b);
            got = {got[6:0], b};
        end
        finish_xfer();
    endtask

    initial begin
        logic [7:0]  got;
        logic        b;
        logic [15:0] exp_cnt;

        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 16'd0;

        vecs[0] = '{0, 3'b110, 32'h0000_A500, 32'h0000_FF00, 8'hA5, 2'd1};
        vecs[1] = '{2, 3'b100, 32'h0000_003C, 32'h0000_003C, 8'h3C, 2'd0};
        vecs[2] = '{0, 3'b001, 32'h3010_0000, 32'h3010_0000, 8'h00, 2'd2};
        vecs[3] = '{1, 3'b001, 32'h1030_0000, 32'h1030_0000, 8'h20, 2'd2};
        vecs[4] = '{0, 3'b111, 32'hC300_0000, 32'hC300_0000, 8'hC3, 2'd3};
        vecs[5] = '{0, 3'b010, 32'h0000_807F, 32'h0000_807F, 8'h01, 2'd1};

        reset    = 1'b1;
        sif.cs_n = 1'b1;
        sif.sclk = 1'b0;
        sif.di   = 1'b0;
        ch_data  = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset_do_out", sif.do_out, 1'b0);
        check("reset_do_oe", sif.do_oe, 1'b0);
        check("reset_sars", sif.sars, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_last_ch", last_ch, 2'd0);
        check("reset_conv_count", conv_count, 16'd0);
        check("reset_state", state_dbg, IDLE);

        for (int v = 0; v < 6; v++) begin
            ch_data = vecs[v].ch_pre;
            full_xfer(vecs[v].lead, vecs[v].addr, vecs[v].ch_post, got);
            exp_cnt = exp_cnt + 16'd1;
            check($sformatf("vec%0d_byte", v), got, vecs[v].exp_byte);
            check($sformatf("vec%0d_last_ch", v), last_ch, vecs[v].exp_ch);
            check($sformatf("vec%0d_conv_count", v), conv_count, exp_cnt);
        end

        // Deselect after three data bits aborts without counting.
        ch_data = 32'h0000_A500;
        start_xfer(0, 3'b110);
        settle();
        for (int i = 0; i < 3; i++) data_bit(b);
        sif.cs_n = 1'b1;
        half();
        check("abort_do_oe", sif.do_oe, 1'b0);
        check("abort_sars", sif.sars, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_conv_count", conv_count, exp_cnt);
        check("abort_last_ch", last_ch, 2'd1);

        ch_data = 32'h0000_003C;
        full_xfer(0, 3'b100, 32'h0000_003C, got);
        exp_cnt = exp_cnt + 16'd1;
        check("post_abort_byte", got, 8'h3C);
        check("post_abort_conv_count", conv_count, exp_cnt);

        // Reset during DATA with cs_n held low.
        ch_data = 32'h0000_A500;
        start_xfer(0, 3'b110);
        settle();
        for (int i = 0; i < 3; i++) data_bit(b);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_do_out", sif.do_out, 1'b0);
        check("midreset_do_oe", sif.do_oe, 1'b0);
        check("midreset_sars", sif.sars, 1'b0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_last_ch", last_ch, 2'd0);
        check("midreset_conv_count", conv_count, 16'd0);
        exp_cnt = 16'd0;

        ch_data = 32'hC300_0000;
        full_xfer(0, 3'b111, 32'hC300_0000, got);
        exp_cnt = exp_cnt + 16'd1;
        check("after_reset_byte", got, 8'hC3);
        check("after_reset_last_ch", last_ch, 2'd3);
        check("after_reset_conv_count", conv_count, exp_cnt);

        // Counter wrap.
        force dut.conv_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.conv_count_q;
        @(negedge clk);
        ch_data = 32'h0000_A500;
        full_xfer(0, 3'b110, 32'h0000_A500, got);
        check("wrap_byte", got, 8'hA5);
        check("wrap_conv_count", conv_count, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
